// File: rtl/borrow_lookahead_subtractor_seq.sv
// Multi-cycle subtractor: Diff = A_In - B_In - B_In_Borrow, CHUNK bits per cycle,
// least-significant chunk first. Borrow lookahead inside a chunk, registered borrow
// between chunks. Result registers update only when the last chunk completes.
// CHUNK must divide WIDTH exactly.
module borrow_lookahead_subtractor_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A_In,
  input  logic [WIDTH-1:0] B_In,
  input  logic             B_In_Borrow,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             B_Out,
  output logic             Overflow
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;       // minuend, shifted right one chunk per cycle
  logic [WIDTH-1:0] b_q, b_d;       // subtrahend, shifted alongside a_q
  logic [WIDTH-1:0] acc_q, acc_d;   // partial difference, filled from the top
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d; // sign bits kept because a_q/b_q are shifted away
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] ca, cb, gb, pb, cd;
  logic [CHUNK:0]   bv;
  logic [WIDTH-1:0] acc_next;
  logic             last_chunk;

  // Borrow generate/propagate across the current chunk.
  always_comb begin
    ca    = a_q[CHUNK-1:0];
    cb    = b_q[CHUNK-1:0];
    gb    = ~ca & cb;
    pb    = ~(ca ^ cb);
    bv    = '0;
    bv[0] = borrow_q;
    cd    = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      bv[i+1] = gb[i] | (pb[i] & bv[i]);
      cd[i]   = ca[i] ^ cb[i] ^ bv[i];
    end
  end

  // New chunk lands in the top CHUNK bits; after N shifts chunk 0 sits at bit 0.
  assign acc_next   = (acc_q >> CHUNK) | (WIDTH'(cd) << (WIDTH - CHUNK));
  assign last_chunk = (cnt_q == CntW'(N - 1));

  // Next-state: operand load on accepted Start, chunk step in RUN, result commit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    b_out_d  = b_out_q;
    ovf_d    = ovf_q;
    case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          a_d      = A_In;
          b_d      = B_In;
          borrow_d = B_In_Borrow;
          a_msb_d  = A_In[WIDTH-1];
          b_msb_d  = B_In[WIDTH-1];
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end else begin
          state_d  = StIdle;
        end
      end
      StRun: begin
        a_d      = a_q >> CHUNK;
        b_d      = b_q >> CHUNK;
        acc_d    = acc_next;
        borrow_d = bv[CHUNK];
        cnt_d    = cnt_q + CntW'(1);
        if (last_chunk) begin
          diff_d  = acc_next;
          b_out_d = bv[CHUNK];
          ovf_d   = (a_msb_q != b_msb_q) && (cd[CHUNK-1] != a_msb_q);
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      b_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      b_out_q  <= b_out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Busy     = (state_q == StRun);
  assign Done     = (state_q == StDone);
  assign Diff     = diff_q;
  assign B_Out    = b_out_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_borrow_lookahead_subtractor_seq.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor pops
// and compares them whenever Done is seen, including the expected Done cycle.
module tb_borrow_lookahead_subtractor_seq;

  localparam int N = 4;

  logic        Clk = 1'b0;
  logic        Reset, Start, B_In_Borrow;
  logic [31:0] A_In, B_In;
  logic        Busy, Done, B_Out, Overflow;
  logic [31:0] Diff;

  typedef struct {
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  borrow_lookahead_subtractor_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .A_In        (A_In),
    .B_In        (B_In),
    .B_In_Borrow (B_In_Borrow),
    .Busy        (Busy),
    .Done        (Done),
    .Diff        (Diff),
    .B_Out       (B_Out),
    .Overflow    (Overflow)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first RUN cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic bin,
                       input logic [31:0] ed, input logic eb, input logic eo, input bit push);
    exp_t e;
    Start       = 1'b1;
    A_In        = a;
    B_In        = b;
    B_In_Borrow = bin;
    if (push) begin
      e.diff = ed;
      e.bout = eb;
      e.ovf  = eo;
      e.cyc  = cyc + 1 + N;
      exp_q.push_back(e);
    end
    @(negedge Clk);
    Start = 1'b0;
    A_In  = 32'hDEAD_BEEF;
    B_In  = 32'h0BAD_F00D;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && Done !== 1'b1; i++) @(negedge Clk);
    if (Done !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_done: got no Done expected Done within 20 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input logic [31:0] ed, input logic eb, input logic eo);
    issue(a, b, bin, ed, eb, eo, 1'b1);
    wait_done();
    @(negedge Clk);
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got Done=1 expected no Done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("diff", Diff, e.diff);
        chk("b_out", 32'(B_Out), 32'(e.bout));
        chk("overflow", 32'(Overflow), 32'(e.ovf));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; A_In = '0; B_In = '0; B_In_Borrow = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_diff", Diff, 32'd0);
    chk("rst_bout", 32'(B_Out), 32'd0);
    chk("rst_ovf", 32'(Overflow), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // 5 - 3 with explicit Busy/Done timing.
    issue(32'h5, 32'h3, 1'b0, 32'h2, 1'b0, 1'b0, 1'b1);
    chk("t1_busy1", 32'(Busy), 32'd1);
    for (int i = 2; i <= N; i++) begin
      @(negedge Clk);
      chk("t1_busy_n", 32'({Busy, Done}), 32'b10);
    end
    @(negedge Clk);
    chk("t1_done_cycle", 32'({Busy, Done}), 32'b01);
    @(negedge Clk);
    chk("t1_after", 32'({Busy, Done}), 32'b00);
    chk("t1_hold", Diff, 32'h2);

    // Borrow across all chunks.
    run_op(32'h0, 32'h1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op(32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    // Signed overflow both directions.
    run_op(32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
    // Borrow-in with all-ones subtrahend returns A.
    run_op(32'h1234_ABCD, 32'hFFFF_FFFF, 1'b1, 32'h1234_ABCD, 1'b1, 1'b0);

    // Back-to-back: Start in the Done cycle.
    issue(32'h1234_5678, 32'h0234_5679, 1'b0, 32'h0FFF_FFFF, 1'b0, 1'b0, 1'b1);
    wait_done();
    issue(32'd10, 32'd4, 1'b0, 32'd6, 1'b0, 1'b0, 1'b1);
    chk("b2b_busy", 32'(Busy), 32'd1);
    chk("b2b_hold", Diff, 32'h0FFF_FFFF);
    wait_done();
    @(negedge Clk);

    // Start during RUN is ignored.
    issue(32'd100, 32'd20, 1'b0, 32'd80, 1'b0, 1'b0, 1'b1);
    @(negedge Clk);
    Start = 1'b1; A_In = 32'hFFFF_FFFF; B_In = 32'h1; B_In_Borrow = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_done();
    repeat (8) @(negedge Clk);

    // Reset in RUN cycle 3 aborts.
    issue(32'h55, 32'h22, 1'b0, 32'h33, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_diff", Diff, 32'd0);
    chk("abort_bout", 32'(B_Out), 32'd0);
    chk("abort_ovf", 32'(Overflow), 32'd0);
    // Reset and Start together: Start dropped.
    Reset = 1'b1; Start = 1'b1; A_In = 32'h7; B_In = 32'h1;
    @(negedge Clk);
    Reset = 1'b0; Start = 1'b0;
    chk("rst_start_busy", 32'(Busy), 32'd0);
    repeat (6) @(negedge Clk);
    run_op(32'd9, 32'd4, 1'b0, 32'd5, 1'b0, 1'b0);

    repeat (3) @(negedge Clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
